// File: rtl/ysyx_25040111_ifetch_axi.sv
// Instruction-fetch AXI4-Lite read master: one outstanding read per fetch request,
// returning the word with a one-cycle if_ok pulse and error/hang diagnostics.
module ysyx_25040111_ifetch_axi #(
    parameter int unsigned HANG_LIMIT = 1023,
    parameter logic [31:0] NOP_INST   = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_start,
    input  logic [31:0] pc,
    output logic [31:0] inst_t,
    output logic        if_ok,
    output logic        fetch_err,
    output logic        fetch_hang,
    output logic        busy,
    output logic [31:0] araddr,
    output logic        arvalid,
    input  logic        arready,
    input  logic [31:0] rdata,
    input  logic [1:0]  rresp,
    input  logic        rvalid,
    output logic        rready,
    output logic [1:0]  state_dbg
);

    localparam int CW = (HANG_LIMIT < 1) ? 1 : $clog2(HANG_LIMIT + 1);
    localparam logic [CW-1:0] HANG_MAX = CW'(HANG_LIMIT);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] hang_cnt;
    logic          aligned;

    assign aligned = (pc[1:0] == 2'b00);

    // Handshakes: a beat transfers on the rising edge where valid && ready are both 1;
    // arvalid/rready come only from the registered state, so neither depends on bus inputs.
    assign arvalid    = (state == ADDR);
    assign rready     = (state == DATA);
    assign if_ok      = (state == DONE);
    assign busy       = (state != IDLE);
    assign fetch_hang = ((state == ADDR) || (state == DATA)) && (hang_cnt == HANG_MAX);
    assign state_dbg  = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (if_start) state_nxt = aligned ? ADDR : DONE;
            ADDR: if (arready)  state_nxt = DATA;
            DATA: if (rvalid)   state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            araddr    <= '0;
            inst_t    <= '0;
            fetch_err <= 1'b0;
            hang_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (if_start) begin
                        if (aligned) begin
                            araddr   <= pc;
                            hang_cnt <= '0;
                        end else begin
                            inst_t    <= NOP_INST;
                            fetch_err <= 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (hang_cnt != HANG_MAX) hang_cnt <= hang_cnt + CNT_ONE;
                end
                DATA: begin
                    if (hang_cnt != HANG_MAX) hang_cnt <= hang_cnt + CNT_ONE;
                    // Data is only sampled on the R handshake edge; a non-OKAY beat yields a NOP.
                    if (rvalid) begin
                        if (rresp == 2'b00) begin
                            inst_t <= rdata;
                        end else begin
                            inst_t    <= NOP_INST;
                            fetch_err <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    fetch_err <= 1'b0;
                end
                default: begin
                    fetch_err <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ysyx_25040111_ifetch_axi.sv
// Directed bench for ysyx_25040111_ifetch_axi: a small AXI-Lite slave model with
// programmable wait states, driven from one initial block via per-scenario tasks.
module tb_ysyx_25040111_ifetch_axi;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_start = 1'b0;
    logic [31:0] pc = '0;
    logic [31:0] inst_t;
    logic        if_ok, fetch_err, fetch_hang, busy;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready = 1'b0;
    logic [31:0] rdata = '0;
    logic [1:0]  rresp = 2'b00;
    logic        rvalid = 1'b0;
    logic        rready;
    logic [1:0]  state_dbg;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ysyx_25040111_ifetch_axi #(
        .HANG_LIMIT(8),
        .NOP_INST  (32'h0000_0013)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .if_start  (if_start),
        .pc        (pc),
        .inst_t    (inst_t),
        .if_ok     (if_ok),
        .fetch_err (fetch_err),
        .fetch_hang(fetch_hang),
        .busy      (busy),
        .araddr    (araddr),
        .arvalid   (arvalid),
        .arready   (arready),
        .rdata     (rdata),
        .rresp     (rresp),
        .rvalid    (rvalid),
        .rready    (rready),
        .state_dbg (state_dbg)
    );

    // Called at a falling edge; requests a fetch at the next rising edge and plays the slave.
    // lat counts rising edges from the request edge to the first cycle showing if_ok.
    task automatic run_fetch(input logic [31:0] fpc, input int ar_delay, input int r_delay,
                             input logic [31:0] rd, input logic [1:0] rsp,
                             input bit early_r, input bit noise,
                             output int lat, output logic [31:0] inst, output logic err,
                             output int n_ar, output int n_ok, output int ar_cyc,
                             output bit addr_stable, output bit rready_early, output bit idle_after);
        int  r_cnt;
        bit  done;
        lat = 0; inst = '0; err = 1'b0; n_ar = 0; n_ok = 0; ar_cyc = 0;
        addr_stable = 1'b1; rready_early = 1'b0; idle_after = 1'b0;
        r_cnt = 0; done = 1'b0;
        if_start = 1'b1; pc = fpc; arready = 1'b0; rvalid = 1'b0;
        for (int k = 1; k <= 60 && !done; k++) begin
            @(negedge clk);
            if (lat != 0 && !if_ok) begin
                idle_after = !busy;
                done = 1'b1;
            end else begin
                if (if_ok) begin
                    n_ok++;
                    if (lat == 0) begin
                        lat = k; inst = inst_t; err = fetch_err;
                    end
                end
                if (arvalid) begin
                    if (araddr !== fpc) addr_stable = 1'b0;
                    if (rready) rready_early = 1'b1;
                    arready = (ar_cyc == ar_delay);
                    ar_cyc++;
                    if (arready) n_ar++;
                    rvalid = early_r; rdata = 32'hDEAD_BEEF; rresp = 2'b00;
                end else begin
                    arready = 1'b0;
                    if (rready) begin
                        rvalid = (r_cnt == r_delay); r_cnt++;
                        rdata = rd; rresp = rsp;
                    end else begin
                        rvalid = 1'b0;
                    end
                end
                if_start = noise;
                if (noise) pc = 32'h9000_0000;
            end
        end
        if_start = 1'b0; arready = 1'b0; rvalid = 1'b0;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({arvalid, rready, if_ok, fetch_err, fetch_hang, busy} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl got %b want 000000", {arvalid, rready, if_ok, fetch_err, fetch_hang, busy});
        end
        checks++;
        if (araddr !== 32'h0 || inst_t !== 32'h0 || state_dbg !== 2'd0) begin
            errors++;
            $display("FAIL reset_data araddr %h inst %h state %0d want 0 0 0", araddr, inst_t, state_dbg);
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned();
        int lat, n_ar, n_ok, ar_cyc; logic [31:0] inst; logic err; bit st, re, ia;
        run_fetch(32'h8000_0000, 0, 0, 32'h0010_0093, 2'b00, 1'b0, 1'b0,
                  lat, inst, err, n_ar, n_ok, ar_cyc, st, re, ia);
        checks++;
        if (lat !== 3 || n_ok !== 1) begin
            errors++; $display("FAIL aligned_lat lat %0d ok %0d want 3 1", lat, n_ok);
        end
        checks++;
        if (inst !== 32'h0010_0093 || err !== 1'b0) begin
            errors++; $display("FAIL aligned_data inst %h err %b want 00100093 0", inst, err);
        end
        checks++;
        if (!st || n_ar !== 1 || !ia) begin
            errors++; $display("FAIL aligned_bus stable %0d ar %0d idle %0d want 1 1 1", st, n_ar, ia);
        end
    endtask

    task automatic test_wait_states();
        int lat, n_ar, n_ok, ar_cyc; logic [31:0] inst; logic err; bit st, re, ia;
        run_fetch(32'h8000_0040, 2, 3, 32'h1234_5678, 2'b00, 1'b0, 1'b0,
                  lat, inst, err, n_ar, n_ok, ar_cyc, st, re, ia);
        checks++;
        if (lat !== 8 || n_ok !== 1) begin
            errors++; $display("FAIL wait_lat lat %0d ok %0d want 8 1", lat, n_ok);
        end
        checks++;
        if (ar_cyc !== 3 || !st || inst !== 32'h1234_5678 || err !== 1'b0) begin
            errors++; $display("FAIL wait_bus arcyc %0d stable %0d inst %h err %b want 3 1 12345678 0",
                               ar_cyc, st, inst, err);
        end
    endtask

    task automatic test_misaligned();
        int lat, n_ar, n_ok, ar_cyc; logic [31:0] inst; logic err; bit st, re, ia;
        run_fetch(32'h8000_0002, 0, 0, 32'hFFFF_FFFF, 2'b00, 1'b0, 1'b0,
                  lat, inst, err, n_ar, n_ok, ar_cyc, st, re, ia);
        checks++;
        if (lat !== 1 || ar_cyc !== 0) begin
            errors++; $display("FAIL misalign_lat lat %0d arcyc %0d want 1 0", lat, ar_cyc);
        end
        checks++;
        if (inst !== 32'h0000_0013 || err !== 1'b1) begin
            errors++; $display("FAIL misalign_data inst %h err %b want 00000013 1", inst, err);
        end
        checks++;
        if (!ia || fetch_err !== 1'b0) begin
            errors++; $display("FAIL misalign_clear idle %0d err %b want 1 0", ia, fetch_err);
        end
    endtask

    task automatic test_rresp_err();
        int lat, n_ar, n_ok, ar_cyc; logic [31:0] inst; logic err; bit st, re, ia;
        run_fetch(32'h8000_0008, 0, 0, 32'hCAFE_F00D, 2'b10, 1'b0, 1'b0,
                  lat, inst, err, n_ar, n_ok, ar_cyc, st, re, ia);
        checks++;
        if (lat !== 3 || inst !== 32'h0000_0013 || err !== 1'b1) begin
            errors++; $display("FAIL rresp_err lat %0d inst %h err %b want 3 00000013 1", lat, inst, err);
        end
    endtask

    task automatic test_ignored_start();
        int lat, n_ar, n_ok, ar_cyc; logic [31:0] inst; logic err; bit st, re, ia;
        run_fetch(32'h8000_0010, 1, 1, 32'h0000_0517, 2'b00, 1'b0, 1'b1,
                  lat, inst, err, n_ar, n_ok, ar_cyc, st, re, ia);
        checks++;
        if (n_ar !== 1 || n_ok !== 1 || lat !== 5) begin
            errors++; $display("FAIL ignored_count ar %0d ok %0d lat %0d want 1 1 5", n_ar, n_ok, lat);
        end
        checks++;
        if (!st || !ia || inst !== 32'h0000_0517) begin
            errors++; $display("FAIL ignored_state stable %0d idle %0d inst %h want 1 1 00000517", st, ia, inst);
        end
    endtask

    task automatic test_early_rvalid();
        int lat, n_ar, n_ok, ar_cyc; logic [31:0] inst; logic err; bit st, re, ia;
        run_fetch(32'h8000_0020, 2, 0, 32'h00A0_0513, 2'b00, 1'b1, 1'b0,
                  lat, inst, err, n_ar, n_ok, ar_cyc, st, re, ia);
        checks++;
        if (re || inst !== 32'h00A0_0513 || lat !== 5) begin
            errors++; $display("FAIL early_rvalid rready_in_addr %0d inst %h lat %0d want 0 00a00513 5", re, inst, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, n_ar, n_ok, ar_cyc; logic [31:0] inst; logic err; bit st, re, ia;
        run_fetch(32'h8000_0100, 0, 0, 32'h1111_1111, 2'b00, 1'b0, 1'b0,
                  lat, inst, err, n_ar, n_ok, ar_cyc, st, re, ia);
        run_fetch(32'h8000_0104, 0, 0, 32'h2222_2222, 2'b00, 1'b0, 1'b0,
                  lat, inst, err, n_ar, n_ok, ar_cyc, st, re, ia);
        checks++;
        if (lat !== 3 || inst !== 32'h2222_2222 || !st) begin
            errors++; $display("FAIL back_to_back lat %0d inst %h stable %0d want 3 22222222 1", lat, inst, st);
        end
    endtask

    task automatic test_hang_reset();
        int lat, n_ar, n_ok, ar_cyc; logic [31:0] inst; logic err; bit st, re, ia;
        if_start = 1'b1; pc = 32'h8000_0200; arready = 1'b0; rvalid = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if_start = 1'b0;
            if (k == 8) begin
                checks++;
                if (fetch_hang !== 1'b0 || arvalid !== 1'b1) begin
                    errors++; $display("FAIL hang_early hang %b arvalid %b want 0 1", fetch_hang, arvalid);
                end
            end
            if (k == 9 || k == 12) begin
                checks++;
                if (fetch_hang !== 1'b1 || arvalid !== 1'b1) begin
                    errors++; $display("FAIL hang_set cycle %0d hang %b arvalid %b want 1 1", k, fetch_hang, arvalid);
                end
            end
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({arvalid, rready, if_ok, fetch_err, fetch_hang, busy} !== 6'b0 || araddr !== 32'h0 || inst_t !== 32'h0) begin
            errors++;
            $display("FAIL async_reset ctrl %b araddr %h inst %h want 000000 0 0",
                     {arvalid, rready, if_ok, fetch_err, fetch_hang, busy}, araddr, inst_t);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        run_fetch(32'h8000_0300, 1, 0, 32'h0050_0113, 2'b00, 1'b0, 1'b0,
                  lat, inst, err, n_ar, n_ok, ar_cyc, st, re, ia);
        checks++;
        if (lat !== 4 || inst !== 32'h0050_0113 || err !== 1'b0 || fetch_hang !== 1'b0) begin
            errors++; $display("FAIL post_reset lat %0d inst %h err %b hang %b want 4 00500113 0 0",
                               lat, inst, err, fetch_hang);
        end
    endtask

    initial begin
        test_reset();
        test_aligned();
        test_wait_states();
        test_misaligned();
        test_rresp_err();
        test_ignored_start();
        test_early_rvalid();
        test_back_to_back();
        test_hang_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ysyx_25040111_ifetch_axi.md
# ysyx_25040111_ifetch_axi

Instruction-fetch bus master between the fetch-control stage and the instruction memory bus. It accepts a one-cycle fetch request (`if_start` plus `pc`) and performs one AXI4-Lite read transaction. It returns the instruction word on `inst_t` with a one-cycle `if_ok` pulse, which the fetch-control stage latches into its instruction register. It also flags misaligned fetches, bus errors and stalled transactions.

## Interface
- `HANG_LIMIT`, default 1023: cycles a transaction may stay outstanding before `fetch_hang` asserts.
- `NOP_INST`, default 32'h0000_0013: word driven on `inst_t` when a fetch errors.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: one clock; reset is asynchronous and active-low.
- `if_start` in 1: fetch request pulse; sampled at a rising edge.
- `pc` in 32: fetch address, sampled together with `if_start`.
- `inst_t` out 32: fetched instruction, valid while `if_ok`=1, held afterwards.
- `if_ok` out 1: one-cycle completion pulse.
- `fetch_err` out 1: qualifies `if_ok`; 1 means misaligned address or non-OKAY response.
- `fetch_hang` out 1: level; the outstanding transaction has exceeded `HANG_LIMIT`.
- `busy` out 1: 1 in any state other than IDLE.
- `araddr` out 32: AR address, registered.
- `arvalid` out 1: AR valid.
- `arready` in 1: AR ready.
- `rdata` in 32: R data.
- `rresp` in 2: R response; 2'b00 means OKAY.
- `rvalid` in 1: R valid.
- `rready` out 1: R ready.

## Operation
- FSM states: IDLE, ADDR, DATA, DONE.
- IDLE:
  - `if_start`=1 with `pc[1:0]`=0: latch `pc` into `araddr`, go to ADDR.
  - `if_start`=1 with `pc[1:0]`≠0: no bus access; `inst_t`<=`NOP_INST`, `fetch_err`<=1, go to DONE.
- ADDR:
  - `arvalid`=1 and `araddr` is held stable.
  - On `arvalid & arready`, go to DATA.
  - `arvalid` never drops before its handshake (AXI rule).
- DATA:
  - `rready`=1.
  - On `rvalid & rready`, `inst_t`<=`rdata` if `rresp`==00; otherwise `inst_t`<=`NOP_INST` and `fetch_err`<=1.
  - Then go to DONE.
- DONE:
  - `if_ok`=1 for exactly this one cycle, then return to IDLE.
  - `fetch_err` clears on leaving DONE.
- `if_start` in any state other than IDLE is ignored and has no side effects. Only one transaction is ever outstanding.
- Hang counter:
  - Width is clog2(`HANG_LIMIT`+1). It clears on entry to ADDR and increments each cycle in ADDR or DATA, saturating at `HANG_LIMIT`.
  - `fetch_hang`=1 while counter==`HANG_LIMIT` and the state is ADDR or DATA.
  - The transaction is never abandoned: `fetch_hang` is diagnostic only and clears when the state leaves DATA.
- `rvalid` arriving while in ADDR is not accepted (`rready`=0).
- `rdata` is captured only on the handshake edge.
- `inst_t` holds its last value in every other state.

## Timing
- Reset (`reset`=0, asynchronous) drives:
  - state IDLE, counter 0;
  - `arvalid`=0, `rready`=0, `if_ok`=0, `fetch_err`=0, `fetch_hang`=0, `busy`=0;
  - `araddr`=0, `inst_t`=0.
- Reset asserted mid-transaction drops the transaction immediately, with no `if_ok`. After release, the FSM starts in IDLE.
- `arvalid`, `rready`, `if_ok` and `busy` are decoded from the registered state, so nothing combinational from bus inputs reaches outputs.
- Best-case latency: `if_start` sampled at edge E0; `arvalid`=1 in the cycle after E0.
  - `arready`=1 gives the AR handshake at E1.
  - `rvalid`=1 gives the R handshake at E2.
  - `if_ok`=1 in the cycle after E2 (3 edges after the request).
- Each cycle of `arready` or `rvalid` delay adds one cycle.
- Misaligned fetch: `if_ok`=1 in the cycle after E0.
- Earliest accepted back-to-back request: the edge at the end of the DONE cycle is still ignored; the next `if_start` is accepted on the following edge, in IDLE.

## Test plan
- Aligned fetch, zero-wait slave: `pc`=0x8000_0000, `rdata`=0x0010_0093, `rresp`=00 -> `araddr`=0x8000_0000, one `if_ok` pulse 3 edges after `if_start`, `inst_t`=0x0010_0093, `fetch_err`=0.
- Wait states: `arready` delayed 2 cycles, `rvalid` delayed 3 cycles -> `arvalid`, `araddr` and `rready` held stable throughout; `if_ok` arrives 5 cycles later than the zero-wait case.
- Error paths:
  - `pc`=0x8000_0002 -> no `arvalid`; `if_ok`=1 with `fetch_err`=1 and `inst_t`=0x0000_0013 in the cycle after E0.
  - `rresp`=2'b10 -> same `inst_t`/`fetch_err` response after the R handshake.
- Ignored and early inputs: `if_start` pulses while in ADDR and DATA -> exactly one AR handshake and one `if_ok`. `rvalid` held high during ADDR -> the data is not taken before the AR handshake.
- Hang and reset: `HANG_LIMIT`=8, `arready` held 0 -> `fetch_hang`=1 from the 9th cycle of ADDR with `arvalid` still 1.
  - Then `reset`=0 -> all outputs take reset values immediately, without a clock edge.
  - After release, a new fetch completes normally.
